// File: rtl/d_pattern_player_pkg.sv
`default_nettype none
// ============================================================================
// Module      : d_pattern_player_pkg
// Description : Shared state encoding and segment record layout for the
//               D-line pattern player and its segment ROM.
// Revision    : 1.0 - initial release
// ============================================================================
package d_pattern_player_pkg;

    // Player states, kept as plain constants for legacy tool compatibility
    localparam int         STATE_W  = 2;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PLAY  = 2'd1;
    localparam logic [1:0] ST_FIN   = 2'd2;

    // Width of the duration field in the built-in pattern table
    localparam int         TBL_DUR_W = 8;

    // One stored segment: level in the top bit, duration in units below it
    typedef struct packed {
        logic                 level;
        logic [TBL_DUR_W-1:0] dur;
    } seg_t;

    // Builds a table entry from a level and a unit count
    function automatic seg_t mk_seg(input logic level, input int units);
        seg_t s;
        s.level = level;
        s.dur   = TBL_DUR_W'(units);
        return s;
    endfunction

endpackage : d_pattern_player_pkg
`default_nettype wire

// File: rtl/d_pattern_rom.sv
`default_nettype none
// ============================================================================
// Module      : d_pattern_rom
// Description : Combinational segment ROM holding the standard latch /
//               flip-flop exercise. Output is {level, duration}; indices at
//               or beyond NUM_SEG read as level 0 for one unit.
// Revision    : 1.0 - initial release
// ============================================================================
module d_pattern_rom
    import d_pattern_player_pkg::*;
#(
    parameter int NUM_SEG = 13,
    parameter int ADDR_W  = 4,
    parameter int DUR_W   = 8
) (
    input  logic [ADDR_W-1:0] i_idx,
    output logic [DUR_W:0]    o_seg
);

    seg_t w_entry;

    // Zero-latency table lookup
    always_comb begin
        w_entry = mk_seg(1'b0, 1);
        if (int'(i_idx) < NUM_SEG) begin
            case (i_idx)
                ADDR_W'(0):  w_entry = mk_seg(1'b0, 4);
                ADDR_W'(1):  w_entry = mk_seg(1'b1, 4);
                ADDR_W'(2):  w_entry = mk_seg(1'b0, 1);
                ADDR_W'(3):  w_entry = mk_seg(1'b1, 2);
                ADDR_W'(4):  w_entry = mk_seg(1'b0, 2);
                ADDR_W'(5):  w_entry = mk_seg(1'b1, 2);
                ADDR_W'(6):  w_entry = mk_seg(1'b0, 1);
                ADDR_W'(7):  w_entry = mk_seg(1'b1, 1);
                ADDR_W'(8):  w_entry = mk_seg(1'b0, 2);
                ADDR_W'(9):  w_entry = mk_seg(1'b1, 1);
                ADDR_W'(10): w_entry = mk_seg(1'b0, 1);
                ADDR_W'(11): w_entry = mk_seg(1'b1, 4);
                ADDR_W'(12): w_entry = mk_seg(1'b0, 4);
                default:     w_entry = mk_seg(1'b0, 1);
            endcase
        end
    end

    assign o_seg = {w_entry.level, DUR_W'(w_entry.dur)};

endmodule : d_pattern_rom
`default_nettype wire

// File: rtl/d_pattern_player.sv
`default_nettype none
// ============================================================================
// Module      : d_pattern_player
// Description : Plays the stored {level, duration} segment list on a single
//               D line, holding each level for max(duration,1) * PRESCALE
//               clocks. Single-shot or looping, abortable at any time.
// Revision    : 1.0 - initial release
// ============================================================================
module d_pattern_player
    import d_pattern_player_pkg::*;
#(
    parameter int NUM_SEG  = 13,
    parameter int ADDR_W   = 4,
    parameter int DUR_W    = 8,
    parameter int PRESCALE = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Loop,
    input  logic              Abort,
    output logic              D_out,
    output logic              Busy,
    output logic              Done,
    output logic [ADDR_W-1:0] Seg_idx
);

    localparam int                PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(PRESCALE - 1);
    localparam logic [ADDR_W-1:0] LAST_SEG = ADDR_W'(NUM_SEG - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [ADDR_W-1:0]  seg_q,   seg_d;
    logic [DUR_W-1:0]   unit_q,  unit_d;
    logic [PRE_W-1:0]   pre_q,   pre_d;
    logic               d_q,     d_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;

    logic [ADDR_W-1:0]  w_next_idx;
    logic [ADDR_W-1:0]  w_rom_addr;
    logic [DUR_W:0]     w_rom_seg;
    logic               w_rom_level;
    logic [DUR_W-1:0]   w_rom_units;
    logic               w_tick;
    logic               w_seg_end;

    // The ROM is always addressed by the segment that would be loaded next:
    // segment 0 when starting from IDLE, otherwise the wrapped successor.
    assign w_next_idx  = (seg_q == LAST_SEG) ? '0 : seg_q + ADDR_W'(1);
    assign w_rom_addr  = (state_q == ST_PLAY) ? w_next_idx : '0;

    d_pattern_rom #(
        .NUM_SEG (NUM_SEG),
        .ADDR_W  (ADDR_W),
        .DUR_W   (DUR_W)
    ) u_rom (
        .i_idx (w_rom_addr),
        .o_seg (w_rom_seg)
    );

    // Duration 0 plays as a single unit
    assign w_rom_level = w_rom_seg[DUR_W];
    assign w_rom_units = (w_rom_seg[DUR_W-1:0] == '0) ? DUR_W'(1) : w_rom_seg[DUR_W-1:0];

    assign w_tick      = (pre_q == '0);
    assign w_seg_end   = w_tick && (unit_q <= DUR_W'(1));

    // Next-state logic: playback sequencing with Abort taking priority
    always_comb begin
        state_d = state_q;
        seg_d   = seg_q;
        unit_d  = unit_q;
        pre_d   = pre_q;
        d_d     = d_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d = ST_PLAY;
                    seg_d   = '0;
                    d_d     = w_rom_level;
                    unit_d  = w_rom_units;
                    pre_d   = PRE_MAX;
                    busy_d  = 1'b1;
                end
            end
            ST_PLAY: begin
                if (w_tick) begin
                    pre_d = PRE_MAX;
                    if (w_seg_end) begin
                        if ((seg_q == LAST_SEG) && !Loop) begin
                            state_d = ST_FIN;
                            seg_d   = '0;
                            unit_d  = '0;
                            pre_d   = '0;
                            d_d     = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            seg_d  = w_next_idx;
                            d_d    = w_rom_level;
                            unit_d = w_rom_units;
                        end
                    end else begin
                        unit_d = unit_q - DUR_W'(1);
                    end
                end else begin
                    pre_d = pre_q - PRE_W'(1);
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                seg_d   = '0;
                unit_d  = '0;
                pre_d   = '0;
                d_d     = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        if (Abort) begin
            state_d = ST_IDLE;
            seg_d   = '0;
            unit_d  = '0;
            pre_d   = '0;
            d_d     = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            seg_q   <= '0;
            unit_q  <= '0;
            pre_q   <= '0;
            d_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            seg_q   <= seg_d;
            unit_q  <= unit_d;
            pre_q   <= pre_d;
            d_q     <= d_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign D_out   = d_q;
    assign Busy    = busy_q;
    assign Done    = done_q;
    assign Seg_idx = seg_q;

endmodule : d_pattern_player
`default_nettype wire

// File: tb/tb_d_pattern_player.sv
`default_nettype none
// ============================================================================
// Module      : tb_d_pattern_player
// Description : Directed bench for d_pattern_player. One instance runs with
//               PRESCALE=1, a second with PRESCALE=3; both share inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_d_pattern_player;

    logic       Clk = 1'b0;
    logic       Reset, Start, Loop, Abort;
    logic       D_out,  Busy,  Done;
    logic [3:0] Seg_idx;
    logic       D3, Busy3, Done3;
    logic [3:0] Seg3;

    int checks = 0;
    int passed = 0;

    // Standard exercise, hand-tabulated: level and units per segment
    int lev [13] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
    int dur [13] = '{4, 4, 1, 2, 2, 2, 1, 1, 2, 1, 1, 4, 4};

    always #5 Clk = ~Clk;

    d_pattern_player #(.NUM_SEG(13), .ADDR_W(4), .DUR_W(8), .PRESCALE(1)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Loop(Loop), .Abort(Abort),
        .D_out(D_out), .Busy(Busy), .Done(Done), .Seg_idx(Seg_idx)
    );

    d_pattern_player #(.NUM_SEG(13), .ADDR_W(4), .DUR_W(8), .PRESCALE(3)) dut_p3 (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Loop(Loop), .Abort(Abort),
        .D_out(D3), .Busy(Busy3), .Done(Done3), .Seg_idx(Seg3)
    );

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Start sampled at the next edge; returns in playback cycle 1
    task automatic kick();
        Start = 1'b1;
        step();
        Start = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        Start = 0; Loop = 0; Abort = 0;
        do_reset();
        checks++;
        if ({D_out, Busy, Done, Seg_idx} !== 7'b0)
            $display("FAIL reset_p1: got d=%b busy=%b done=%b seg=%0d, want all 0", D_out, Busy, Done, Seg_idx);
        else passed++;
        checks++;
        if ({D3, Busy3, Done3, Seg3} !== 7'b0)
            $display("FAIL reset_p3: got d=%b busy=%b done=%b seg=%0d, want all 0", D3, Busy3, Done3, Seg3);
        else passed++;
    endtask

    task automatic test_single_shot();
        int n;
        n = 0;
        step();
        kick();
        for (int s = 0; s < 13; s++) begin
            for (int c = 0; c < dur[s]; c++) begin
                n++;
                checks++;
                if ({D_out, Busy, Done, Seg_idx} !== {lev[s][0], 1'b1, 1'b0, 4'(s)})
                    $display("FAIL single_wave cyc %0d: got d=%b busy=%b done=%b seg=%0d, want d=%0d busy=1 done=0 seg=%0d",
                             n, D_out, Busy, Done, Seg_idx, lev[s], s);
                else passed++;
                step();
            end
        end
        checks++;
        if ({D_out, Busy, Done, Seg_idx} !== {1'b0, 1'b0, 1'b1, 4'd0})
            $display("FAIL single_fin: got d=%b busy=%b done=%b seg=%0d, want d=0 busy=0 done=1 seg=0", D_out, Busy, Done, Seg_idx);
        else passed++;
        step();
        checks++;
        if ({Busy, Done} !== 2'b00)
            $display("FAIL single_after_fin: got busy=%b done=%b, want 0 0", Busy, Done);
        else passed++;
    endtask

    task automatic test_prescale();
        do_reset();
        kick();
        for (int s = 0; s < 13; s++) begin
            for (int c = 0; c < 3 * dur[s]; c++) begin
                checks++;
                if ({D3, Busy3, Done3, Seg3} !== {lev[s][0], 1'b1, 1'b0, 4'(s)})
                    $display("FAIL p3_wave seg %0d sub %0d: got d=%b busy=%b done=%b seg=%0d, want d=%0d busy=1 done=0 seg=%0d",
                             s, c, D3, Busy3, Done3, Seg3, lev[s], s);
                else passed++;
                step();
            end
        end
        checks++;
        if ({D3, Busy3, Done3, Seg3} !== {1'b0, 1'b0, 1'b1, 4'd0})
            $display("FAIL p3_fin: got d=%b busy=%b done=%b seg=%0d, want d=0 busy=0 done=1 seg=0", D3, Busy3, Done3, Seg3);
        else passed++;
        step();
        checks++;
        if (Done3 !== 1'b0)
            $display("FAIL p3_done_width: got done=%b, want 0", Done3);
        else passed++;
    endtask

    task automatic test_loop();
        do_reset();
        Loop = 1'b1;
        kick();
        for (int p = 0; p < 2; p++) begin
            for (int s = 0; s < 13; s++) begin
                for (int c = 0; c < dur[s]; c++) begin
                    checks++;
                    if ({D_out, Busy, Done, Seg_idx} !== {lev[s][0], 1'b1, 1'b0, 4'(s)})
                        $display("FAIL loop_wave pass %0d seg %0d: got d=%b busy=%b done=%b seg=%0d, want d=%0d busy=1 done=0 seg=%0d",
                                 p, s, D_out, Busy, Done, Seg_idx, lev[s], s);
                    else passed++;
                    step();
                end
            end
        end
        checks++;
        if ({Busy, Done, Seg_idx} !== {1'b1, 1'b0, 4'd0})
            $display("FAIL loop_third_pass: got busy=%b done=%b seg=%0d, want busy=1 done=0 seg=0", Busy, Done, Seg_idx);
        else passed++;
        Abort = 1'b1;
        step();
        Abort = 1'b0;
        Loop  = 1'b0;
        checks++;
        if ({D_out, Busy, Done, Seg_idx} !== 7'b0)
            $display("FAIL loop_abort: got d=%b busy=%b done=%b seg=%0d, want all 0", D_out, Busy, Done, Seg_idx);
        else passed++;
    endtask

    task automatic test_abort();
        do_reset();
        kick();
        for (int n = 1; n < 10; n++) step();
        // playback cycle 10 is segment 3 (level 1)
        checks++;
        if ({D_out, Busy, Seg_idx} !== {1'b1, 1'b1, 4'd3})
            $display("FAIL abort_pre: got d=%b busy=%b seg=%0d, want d=1 busy=1 seg=3", D_out, Busy, Seg_idx);
        else passed++;
        Abort = 1'b1;
        step();
        Abort = 1'b0;
        checks++;
        if ({D_out, Busy, Done, Seg_idx} !== 7'b0)
            $display("FAIL abort_idle: got d=%b busy=%b done=%b seg=%0d, want all 0", D_out, Busy, Done, Seg_idx);
        else passed++;
        kick();
        checks++;
        if ({D_out, Busy, Done, Seg_idx} !== {1'b0, 1'b1, 1'b0, 4'd0})
            $display("FAIL abort_restart: got d=%b busy=%b done=%b seg=%0d, want d=0 busy=1 done=0 seg=0", D_out, Busy, Done, Seg_idx);
        else passed++;
        for (int n = 1; n < 5; n++) step();
        checks++;
        if ({D_out, Busy, Seg_idx} !== {1'b1, 1'b1, 4'd1})
            $display("FAIL abort_restart_seg1: got d=%b busy=%b seg=%0d, want d=1 busy=1 seg=1", D_out, Busy, Seg_idx);
        else passed++;
        Abort = 1'b1;
        step();
        Abort = 1'b0;
        for (int n = 0; n < 3; n++) begin
            checks++;
            if ({Busy, Done} !== 2'b00)
                $display("FAIL abort_no_done cyc %0d: got busy=%b done=%b, want 0 0", n, Busy, Done);
            else passed++;
            step();
        end
    endtask

    task automatic test_start_ignored();
        int n;
        n = 0;
        do_reset();
        kick();
        for (int s = 0; s < 13; s++) begin
            for (int c = 0; c < dur[s]; c++) begin
                n++;
                checks++;
                if ({D_out, Busy, Done, Seg_idx} !== {lev[s][0], 1'b1, 1'b0, 4'(s)})
                    $display("FAIL restart_wave cyc %0d: got d=%b busy=%b done=%b seg=%0d, want d=%0d busy=1 done=0 seg=%0d",
                             n, D_out, Busy, Done, Seg_idx, lev[s], s);
                else passed++;
                Start = (n == 5 || n == 20);
                step();
                Start = 1'b0;
            end
        end
        checks++;
        if ({Busy, Done} !== 2'b01)
            $display("FAIL restart_fin: got busy=%b done=%b, want busy=0 done=1", Busy, Done);
        else passed++;
        step();
        Start = 1'b1;
        Abort = 1'b1;
        step();
        Start = 1'b0;
        Abort = 1'b0;
        checks++;
        if ({D_out, Busy, Done, Seg_idx} !== 7'b0)
            $display("FAIL start_abort_idle: got d=%b busy=%b done=%b seg=%0d, want all 0", D_out, Busy, Done, Seg_idx);
        else passed++;
        step();
        checks++;
        if (Busy !== 1'b0)
            $display("FAIL start_abort_stay: got busy=%b, want 0", Busy);
        else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        kick();
        // playback cycle 16 is segment 6
        for (int n = 1; n < 16; n++) step();
        checks++;
        if ({D_out, Busy, Seg_idx} !== {1'b0, 1'b1, 4'd6})
            $display("FAIL reset_mid_pre: got d=%b busy=%b seg=%0d, want d=0 busy=1 seg=6", D_out, Busy, Seg_idx);
        else passed++;
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        checks++;
        if ({D_out, Busy, Done, Seg_idx} !== 7'b0)
            $display("FAIL reset_mid: got d=%b busy=%b done=%b seg=%0d, want all 0", D_out, Busy, Done, Seg_idx);
        else passed++;
        for (int n = 0; n < 3; n++) begin
            step();
            checks++;
            if ({Busy, Done} !== 2'b00)
                $display("FAIL reset_mid_idle cyc %0d: got busy=%b done=%b, want 0 0", n, Busy, Done);
            else passed++;
        end
        kick();
        checks++;
        if ({D_out, Busy, Seg_idx} !== {1'b0, 1'b1, 4'd0})
            $display("FAIL reset_mid_restart: got d=%b busy=%b seg=%0d, want d=0 busy=1 seg=0", D_out, Busy, Seg_idx);
        else passed++;
        for (int n = 1; n < 5; n++) step();
        checks++;
        if ({D_out, Seg_idx} !== {1'b1, 4'd1})
            $display("FAIL reset_mid_seg1: got d=%b seg=%0d, want d=1 seg=1", D_out, Seg_idx);
        else passed++;
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Loop = 1'b0; Abort = 1'b0;
        test_reset();
        test_single_shot();
        test_prescale();
        test_loop();
        test_abort();
        test_start_ignored();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_d_pattern_player
`default_nettype wire
